// File: rtl/bist_adder_pkg.sv
// Shared definitions for the self-testing adder: FSM states, vector count
// and the built-in vector table.
package bist_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NUM_VEC = 8;

    typedef enum logic [2:0] {
        F_X,
        F_Y,
        F_CIN,
        F_SUM,
        F_COUT
    } vec_field_t;

    // One field of built-in vector k for a given adder width; single-bit
    // fields come back in bit 0, multi-bit fields are masked to width.
    function automatic logic [63:0] vec_field(input int unsigned width,
                                              input logic [2:0]  k,
                                              input vec_field_t  f);
        logic [63:0] ones;
        logic [63:0] p5;
        logic [63:0] pa;
        logic [63:0] vx;
        logic [63:0] vy;
        logic [63:0] vs;
        logic        vc;
        logic        vo;
        ones = '1;
        if (width < 64) ones = (64'd1 << width) - 64'd1;
        p5 = {32{2'b01}} & ones;
        pa = {32{2'b10}} & ones;
        case (k)
            3'd0:    begin vx = '0;   vy = '0;   vc = 1'b0; vs = '0;   vo = 1'b0; end
            3'd1:    begin vx = '0;   vy = ones; vc = 1'b0; vs = ones; vo = 1'b0; end
            3'd2:    begin vx = '0;   vy = ones; vc = 1'b1; vs = '0;   vo = 1'b1; end
            3'd3:    begin vx = ones; vy = '0;   vc = 1'b0; vs = ones; vo = 1'b0; end
            3'd4:    begin vx = ones; vy = '0;   vc = 1'b1; vs = '0;   vo = 1'b1; end
            3'd5:    begin vx = ones; vy = ones; vc = 1'b1; vs = ones; vo = 1'b1; end
            3'd6:    begin vx = p5;   vy = p5;   vc = 1'b0; vs = pa;   vo = 1'b0; end
            default: begin vx = pa;   vy = pa;   vc = 1'b1; vs = p5;   vo = 1'b1; end
        endcase
        case (f)
            F_X:     return vx;
            F_Y:     return vy;
            F_CIN:   return {63'd0, vc};
            F_SUM:   return vs;
            default: return {63'd0, vo};
        endcase
    endfunction

endpackage

// File: rtl/adder_n.sv
// Purely combinational WIDTH-bit adder with carry in/out.
module adder_n #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);

endmodule

// File: rtl/bist_adder_n.sv
// Registered-operand adder with a built-in self-test that applies eight
// fixed vectors and records which of them miscompared.
module bist_adder_n
    import bist_adder_pkg::*;
#(
    parameter  int unsigned WIDTH   = 16,
    localparam int unsigned NUM_VEC = bist_adder_pkg::NUM_VEC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               test_en,
    input  logic               start,
    input  logic               inj_fault,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               c0,
    output logic [WIDTH-1:0]   sum,
    output logic               carry_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_mask,
    output logic [2:0]         first_fail
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       vec_idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             launch;
    logic             advance;
    logic [2:0]       cur_k;
    logic [2:0]       chk_k;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             miscmp;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        if (!en || !test_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nxt = RUN;
                        launch    = 1'b1;
                    end
                end
                RUN:     if (vec_idx == 4'(NUM_VEC)) state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // vec_idx is the vector loaded at the next edge; the one one behind it
    // is the vector whose result is currently on sum/carry_out.
    assign advance  = (state == RUN) && en && test_en;
    assign cur_k    = vec_idx[2:0];
    assign chk_k    = cur_k - 3'd1;
    assign exp_sum  = WIDTH'(vec_field(WIDTH, chk_k, F_SUM));
    assign exp_cout = 1'(vec_field(WIDTH, chk_k, F_COUT));
    assign miscmp   = {carry_out ^ inj_fault, sum} != {exp_cout, exp_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx    <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
        end else if (launch) begin
            vec_idx    <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
        end else if (advance) begin
            if (vec_idx != 4'd0) begin
                fail_mask[chk_k] <= miscmp;
                if (miscmp && (fail_mask == '0)) first_fail <= chk_k;
            end
            if (vec_idx != 4'(NUM_VEC)) vec_idx <= vec_idx + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (!en) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (!test_en) begin
            a_q   <= x;
            b_q   <= y;
            cin_q <= c0;
        end else if (advance && (vec_idx != 4'(NUM_VEC))) begin
            a_q   <= WIDTH'(vec_field(WIDTH, cur_k, F_X));
            b_q   <= WIDTH'(vec_field(WIDTH, cur_k, F_Y));
            cin_q <= 1'(vec_field(WIDTH, cur_k, F_CIN));
        end
    end

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (sum),
        .cout (carry_out)
    );

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (fail_mask == '0);

endmodule

// File: tb/tb_bist_adder_n.sv
// Directed bench for bist_adder_n at WIDTH 16, 4 and 64 sharing one set of
// control inputs.
module tb_bist_adder_n;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b0;
    logic        test_en   = 1'b0;
    logic        start     = 1'b0;
    logic        inj_fault = 1'b0;
    logic        c0        = 1'b0;
    logic [15:0] x16       = '0;
    logic [15:0] y16       = '0;
    logic [3:0]  x4        = '0;
    logic [3:0]  y4        = '0;
    logic [63:0] x64       = '0;
    logic [63:0] y64       = '0;

    logic [15:0] sum16;
    logic [3:0]  sum4;
    logic [63:0] sum64;
    logic        carry16, carry4, carry64;
    logic        busy16, busy4, busy64;
    logic        done16, done4, done64;
    logic        pass16, pass4, pass64;
    logic [7:0]  mask16, mask4, mask64;
    logic [2:0]  ff16, ff4, ff64;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    always #5 clk = ~clk;

    bist_adder_n #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .test_en(test_en), .start(start),
        .inj_fault(inj_fault), .x(x16), .y(y16), .c0(c0), .sum(sum16),
        .carry_out(carry16), .busy(busy16), .done(done16), .pass(pass16),
        .fail_mask(mask16), .first_fail(ff16)
    );

    bist_adder_n #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .test_en(test_en), .start(start),
        .inj_fault(inj_fault), .x(x4), .y(y4), .c0(c0), .sum(sum4),
        .carry_out(carry4), .busy(busy4), .done(done4), .pass(pass4),
        .fail_mask(mask4), .first_fail(ff4)
    );

    bist_adder_n #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .en(en), .test_en(test_en), .start(start),
        .inj_fault(inj_fault), .x(x64), .y(y64), .c0(c0), .sum(sum64),
        .carry_out(carry64), .busy(busy64), .done(done64), .pass(pass64),
        .fail_mask(mask64), .first_fail(ff64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then step while busy; inj_j bit j drives inj_fault for the
    // edge following step j, and start is re-pulsed at step start_j.
    task automatic run_bist(input logic [31:0] inj_j, input int start_j,
                            input bit probe, output int cycles);
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (busy16 && cycles < 20) begin
            inj_fault = inj_j[cycles];
            start     = (cycles == start_j);
            if (probe && cycles == 5) begin
                check("live_v4_sum",  64'(sum16),   64'h0);
                check("live_v4_cout", 64'(carry16), 64'h1);
            end
            if (probe && cycles == 7) begin
                check("live_v6_sum",  64'(sum16),   64'hAAAA);
                check("live_v6_cout", 64'(carry16), 64'h0);
            end
            tick();
            cycles++;
        end
        inj_fault = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_sum",   64'(sum16),   64'h0);
        check("rst_cout",  64'(carry16), 64'h0);
        check("rst_busy",  64'(busy16),  64'h0);
        check("rst_done",  64'(done16),  64'h0);
        check("rst_pass",  64'(pass16),  64'h0);
        check("rst_mask",  64'(mask16),  64'h0);
        check("rst_first", 64'(ff16),    64'h0);
        #1 rst_n = 1'b1;
        tick();

        en = 1'b1; test_en = 1'b0;
        x16 = 16'hFFFF; y16 = 16'h0001; c0 = 1'b0;
        tick();
        check("fn_ffff_sum",  64'(sum16),   64'h0);
        check("fn_ffff_cout", 64'(carry16), 64'h1);
        x16 = 16'h1234; y16 = 16'h4321; c0 = 1'b1;
        tick();
        check("fn_mix_sum",  64'(sum16),   64'h5556);
        check("fn_mix_cout", 64'(carry16), 64'h0);
        x16 = 16'h8000; y16 = 16'h8000; c0 = 1'b1;
        tick();
        check("fn_msb_sum",  64'(sum16),   64'h0001);
        check("fn_msb_cout", 64'(carry16), 64'h1);

        en = 1'b0;
        tick();
        check("en0_sum",  64'(sum16),   64'h0);
        check("en0_cout", 64'(carry16), 64'h0);
        test_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("en0_nostart", 64'(busy16), 64'h0);

        en = 1'b1;
        run_bist('0, -1, 1'b1, cyc);
        check("run_cycles", 64'(cyc),     64'd9);
        check("run_done",   64'(done16),  64'h1);
        check("run_pass",   64'(pass16),  64'h1);
        check("run_mask",   64'(mask16),  64'h0);
        check("run_first",  64'(ff16),    64'h0);
        check("run_v7_sum", 64'(sum16),   64'h5555);
        check("run_v7_cout",64'(carry16), 64'h1);
        check("w4_pass",    64'(pass4),   64'h1);
        check("w4_v7_sum",  64'(sum4),    64'h5);
        check("w4_v7_cout", 64'(carry4),  64'h1);
        check("w64_pass",   64'(pass64),  64'h1);
        check("w64_v7_sum", sum64,        64'h5555_5555_5555_5555);
        check("w64_v7_cout",64'(carry64), 64'h1);
        tick();
        check("done_hold",  64'(done16),  64'h1);

        run_bist('1, 3, 1'b0, cyc);
        check("inj_cycles", 64'(cyc),    64'd9);
        check("inj_done",   64'(done16), 64'h1);
        check("inj_pass",   64'(pass16), 64'h0);
        check("inj_mask",   64'(mask16), 64'hFF);
        check("inj_first",  64'(ff16),   64'h0);
        check("inj_w4_mask",64'(mask4),  64'hFF);

        run_bist(32'h50, -1, 1'b0, cyc);
        check("part_done",  64'(done16), 64'h1);
        check("part_pass",  64'(pass16), 64'h0);
        check("part_mask",  64'(mask16), 64'h28);
        check("part_first", 64'(ff16),   64'h3);

        inj_fault = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        inj_fault = 1'b0;
        tick();
        test_en = 1'b0;
        tick();
        check("abort_busy",  64'(busy16), 64'h0);
        check("abort_done",  64'(done16), 64'h0);
        check("abort_mask",  64'(mask16), 64'h03);
        check("abort_first", 64'(ff16),   64'h0);
        test_en = 1'b1;
        tick();
        check("abort_idle", 64'(busy16), 64'h0);
        run_bist('0, -1, 1'b0, cyc);
        check("post_abort_cycles", 64'(cyc),    64'd9);
        check("post_abort_pass",   64'(pass16), 64'h1);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_sum",  64'(sum16),   64'h0);
        check("mrst_cout", 64'(carry16), 64'h0);
        check("mrst_busy", 64'(busy16),  64'h0);
        check("mrst_done", 64'(done16),  64'h0);
        check("mrst_mask", 64'(mask16),  64'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("mrst_idle", 64'(busy16 | done16), 64'h0);
        run_bist('0, -1, 1'b0, cyc);
        check("post_rst_cycles", 64'(cyc),    64'd9);
        check("post_rst_pass",   64'(pass16), 64'h1);
        check("post_rst_mask",   64'(mask16), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
